// File: rtl/cache_pkg.sv
// Shared definitions for the n-way cache controller: line-state codes,
// CPU request codes and the controller FSM state type.
package cache_pkg;

  // Line-state codes; anything at or above ST_INVALID is an invalid line.
  localparam logic [2:0] ST_UC      = 3'b000;
  localparam logic [2:0] ST_UD      = 3'b001;
  localparam logic [2:0] ST_SC      = 3'b010;
  localparam logic [2:0] ST_SD      = 3'b011;
  localparam logic [2:0] ST_INVALID = 3'b100;

  // CPU request codes; the remaining codes mean no task.
  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StAllocate,
    StUpgrade
  } ctrl_state_e;

  function automatic logic line_valid(input logic [2:0] code);
    return code < ST_INVALID;
  endfunction

  function automatic logic line_dirty(input logic [2:0] code);
    return (code == ST_UD) || (code == ST_SD);
  endfunction

endpackage

// File: rtl/victim_select.sv
// Replacement victim choice: lowest-index invalid way wins, otherwise the
// round-robin pointer way, which then advances.
module victim_select #(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] way_invalid,
  input  logic                advance,
  output logic [WAY_W-1:0]    victim
);

  logic [WAY_W-1:0] ptr_q, ptr_d;
  logic             any_invalid;

  // Priority pick of the first invalid way, falling back to the pointer.
  always_comb begin
    any_invalid = 1'b0;
    victim      = ptr_q;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_invalid[i]) begin
        any_invalid = 1'b1;
        victim      = WAY_W'(i);
      end
    end
  end

  // Pointer moves only when it actually supplied the victim.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && !any_invalid) begin
      ptr_d = (ptr_q == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cache_controller_nway.sv
// N-way set-associative cache controller: hit lookup, dirty writeback,
// allocation from the interconnect and shared-to-unique upgrade over ACE.
module cache_controller_nway
  import cache_pkg::*;
#(
  parameter int WIDTH_STATE = 3,
  parameter int NUM_WAYS = 4,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      cpu_request,
  output logic                            cache_ready,
  output logic                            cache_complete,
  input  logic [NUM_WAYS-1:0]             way_hit,
  input  logic [NUM_WAYS*WIDTH_STATE-1:0] way_state,
  input  logic                            ace_ready,
  input  logic                            ace_resp_shared,
  output logic                            read_req,
  output logic                            write_req,
  output logic                            invalid_req,
  output logic                            write_from_cpu,
  output logic                            write_from_interconnect,
  output logic [WAY_W-1:0]                sel_way,
  output logic                            state_we,
  output logic [WIDTH_STATE-1:0]          new_state
);

  ctrl_state_e      state_q, state_d;
  logic             op_write_q, op_write_d;
  logic [WAY_W-1:0] way_q, way_d;

  logic [NUM_WAYS-1:0] way_inv, way_eff_hit;
  logic                hit;
  logic [WAY_W-1:0]    hit_way, victim;
  logic [2:0]          hit_code, victim_code;
  logic                hit_owned, lookup_miss;

  // Per-way hit qualification and lowest-index hit selection.
  always_comb begin
    way_inv     = '0;
    way_eff_hit = '0;
    hit         = 1'b0;
    hit_way     = '0;
    hit_code    = ST_INVALID;
    for (int i = 0; i < NUM_WAYS; i++) begin
      way_inv[i]     = !line_valid(3'(way_state[i*WIDTH_STATE +: WIDTH_STATE]));
      way_eff_hit[i] = way_hit[i] && !way_inv[i];
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_eff_hit[i]) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(i);
        hit_code = 3'(way_state[i*WIDTH_STATE +: WIDTH_STATE]);
      end
    end
  end

  assign victim_code = 3'(way_state[int'(victim)*WIDTH_STATE +: WIDTH_STATE]);
  // Unique ownership lets a write hit complete without an upgrade.
  assign hit_owned   = (hit_code == ST_UC) || (hit_code == ST_UD);
  assign lookup_miss = (state_q == StLookup) && !hit;

  victim_select #(
    .NUM_WAYS(NUM_WAYS)
  ) u_victim_select (
    .clk        (clk),
    .reset      (reset),
    .way_invalid(way_inv),
    .advance    (lookup_miss),
    .victim     (victim)
  );

  // State, latched operation and target way registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      way_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      way_q      <= way_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    way_d      = way_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_request == REQ_READ || cpu_request == REQ_WRITE) begin
          op_write_d = (cpu_request == REQ_WRITE);
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          if (!op_write_q || hit_owned) begin
            state_d = StIdle;
          end else begin
            way_d   = hit_way;
            state_d = StUpgrade;
          end
        end else begin
          way_d   = victim;
          state_d = line_dirty(victim_code) ? StWriteback : StAllocate;
        end
      end
      StWriteback: if (ace_ready) state_d = StAllocate;
      StAllocate:  if (ace_ready) state_d = StLookup;
      StUpgrade:   if (ace_ready) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs; reset forces the idle view even before the edge lands.
  always_comb begin
    cache_ready             = 1'b0;
    cache_complete          = 1'b0;
    read_req                = 1'b0;
    write_req               = 1'b0;
    invalid_req             = 1'b0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    sel_way                 = '0;
    state_we                = 1'b0;
    new_state               = '0;
    if (reset) begin
      cache_ready = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: cache_ready = 1'b1;
        StLookup: begin
          sel_way = hit ? hit_way : victim;
          if (hit && !op_write_q) begin
            cache_complete = 1'b1;
            cache_ready    = 1'b1;
          end else if (hit && hit_owned) begin
            write_from_cpu = 1'b1;
            state_we       = 1'b1;
            new_state      = WIDTH_STATE'(ST_UD);
            cache_complete = 1'b1;
          end
        end
        StWriteback: begin
          write_req = 1'b1;
          sel_way   = way_q;
          if (ace_ready) begin
            state_we  = 1'b1;
            new_state = WIDTH_STATE'(ST_INVALID);
          end
        end
        StAllocate: begin
          read_req = 1'b1;
          sel_way  = way_q;
          if (ace_ready) begin
            write_from_interconnect = 1'b1;
            state_we                = 1'b1;
            new_state = ace_resp_shared ? WIDTH_STATE'(ST_SC) : WIDTH_STATE'(ST_UC);
          end
        end
        StUpgrade: begin
          invalid_req = 1'b1;
          sel_way     = way_q;
          if (ace_ready) begin
            write_from_cpu = 1'b1;
            state_we       = 1'b1;
            new_state      = WIDTH_STATE'(ST_UD);
            cache_complete = 1'b1;
          end
        end
        default: cache_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Scoreboard bench: stimulus pushes expected datapath/state events, a
// monitor pops and compares them whenever the controller emits one.
module tb_cache_controller_nway;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cpu_request = 2'b11;
  logic       cache_ready, cache_complete;
  logic [3:0] way_hit = 4'b0000;
  logic [11:0] way_state = 12'h924;
  logic       ace_ready = 1'b0;
  logic       ace_resp_shared = 1'b0;
  logic       read_req, write_req, invalid_req;
  logic       write_from_cpu, write_from_interconnect;
  logic [1:0] sel_way;
  logic       state_we;
  logic [2:0] new_state;

  cache_controller_nway #(
    .WIDTH_STATE(3),
    .NUM_WAYS   (4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cpu_request            (cpu_request),
    .cache_ready            (cache_ready),
    .cache_complete         (cache_complete),
    .way_hit                (way_hit),
    .way_state              (way_state),
    .ace_ready              (ace_ready),
    .ace_resp_shared        (ace_resp_shared),
    .read_req               (read_req),
    .write_req              (write_req),
    .invalid_req            (invalid_req),
    .write_from_cpu         (write_from_cpu),
    .write_from_interconnect(write_from_interconnect),
    .sel_way                (sel_way),
    .state_we               (state_we),
    .new_state              (new_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       we;
    logic [2:0] ns;
    logic       wfc;
    logic       wfi;
    logic       cmp;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  rd_cnt, wr_cnt, inv_cnt;
  int  ace_delay = 1;
  logic [2:0] model_st[4];
  logic [3:0] model_hit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply_model();
    way_hit   = model_hit;
    way_state = {model_st[3], model_st[2], model_st[1], model_st[0]};
  endtask

  task automatic set_model(input logic [3:0] hits, input logic [2:0] s3, input logic [2:0] s2,
                           input logic [2:0] s1, input logic [2:0] s0);
    model_hit   = hits;
    model_st[3] = s3;
    model_st[2] = s2;
    model_st[1] = s1;
    model_st[0] = s0;
    apply_model();
  endtask

  task automatic push(input logic [1:0] sel, input logic we, input logic [2:0] ns,
                      input logic wfc, input logic wfi, input logic cmp);
    ev_t e;
    e = '{sel: sel, we: we, ns: ns, wfc: wfc, wfi: wfi, cmp: cmp};
    exp_q.push_back(e);
  endtask

  // Issue one request from IDLE and wait (bounded) for its completion pulse.
  task automatic run_txn(input logic [1:0] req, output int cycles);
    bit done;
    rd_cnt = 0; wr_cnt = 0; inv_cnt = 0;
    cpu_request = req;
    @(posedge clk); #1;
    cpu_request = 2'b11;
    cycles = 0;
    done = 0;
    while (!done && cycles < 60) begin
      @(negedge clk); #1;
      cycles++;
      if (cache_complete) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: got no cache_complete, want one within 60 cycles");
    end
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  // ACE responder: acknowledges any request after ace_delay cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ace_ready = 1'b0;
        cnt = 0;
      end else begin
        if (ace_ready) cnt = 0;
        if (read_req || write_req || invalid_req) begin
          cnt++;
          ace_ready = (cnt >= ace_delay);
        end else begin
          cnt = 0;
          ace_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: compares events against the scoreboard and updates the tag/state model.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        if (read_req)    rd_cnt++;
        if (write_req)   wr_cnt++;
        if (invalid_req) inv_cnt++;
        if (state_we || cache_complete || write_from_cpu || write_from_interconnect) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got sel=%0d we=%0b cmp=%0b, want none",
                     sel_way, state_we, cache_complete);
          end else begin
            e = exp_q.pop_front();
            chk("ev_sel_way", sel_way, e.sel);
            chk("ev_state_we", state_we, e.we);
            if (e.we) chk("ev_new_state", new_state, e.ns);
            chk("ev_write_from_cpu", write_from_cpu, e.wfc);
            chk("ev_write_from_ic", write_from_interconnect, e.wfi);
            chk("ev_complete", cache_complete, e.cmp);
          end
          if (state_we) model_st[sel_way] = new_state;
          if (write_from_interconnect) model_hit[sel_way] = 1'b1;
          apply_model();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  localparam logic [2:0] UC = 3'b000, UD = 3'b001, SC = 3'b010, SD = 3'b011, INV = 3'b100;

  initial begin
    int cyc;
    bit seen;
    set_model(4'b0000, INV, INV, INV, INV);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_during", cache_ready, 1);
    chk("rst_reqs_during", {read_req, write_req, invalid_req}, 0);
    chk("rst_strobes_during", {state_we, write_from_cpu, write_from_interconnect,
                               cache_complete}, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready_after", cache_ready, 1);
    chk("rst_sel_after", sel_way, 0);
    @(posedge clk); #1;

    // Read hit on way 1 (UC): complete one cycle after acceptance, no ACE traffic.
    set_model(4'b0010, INV, INV, UC, INV);
    push(2'd1, 0, 3'd0, 0, 0, 1);
    run_txn(2'b00, cyc);
    chk("rdhit_latency", cyc, 1);
    chk("rdhit_no_ace", rd_cnt + wr_cnt + inv_cnt, 0);

    // Hit qualification: way 0 tag matches but is INVALID, way 1 UD wins.
    set_model(4'b0011, UC, UC, UD, INV);
    push(2'd1, 0, 3'd0, 0, 0, 1);
    run_txn(2'b00, cyc);
    chk("qual_latency", cyc, 1);

    // Write hit to SC way 2: upgrade, invalid_req held 3 cycles, then UD.
    set_model(4'b0100, INV, SC, INV, INV);
    ace_delay = 3;
    push(2'd2, 1, UD, 1, 0, 1);
    run_txn(2'b01, cyc);
    chk("upg_invalid_cycles", inv_cnt, 3);
    chk("upg_no_rd_wr", rd_cnt + wr_cnt, 0);
    ace_delay = 1;

    // Clean miss: way 3 INVALID is victim, fill shared, replay hits way 3.
    set_model(4'b0000, INV, UC, UC, UC);
    ace_resp_shared = 1'b1;
    push(2'd3, 1, SC, 0, 1, 0);
    push(2'd3, 0, 3'd0, 0, 0, 1);
    run_txn(2'b00, cyc);
    chk("clean_miss_rd_cycles", rd_cnt, 1);
    chk("clean_miss_no_wb", wr_cnt, 0);
    ace_resp_shared = 1'b0;

    // Dirty misses: round-robin victims 0,1,2,3 then wrap to 0.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] p;
      p = 2'(k % 4);
      set_model(4'b0000, UD, UD, UD, UD);
      push(p, 1, INV, 0, 0, 0);
      push(p, 1, UC, 0, 1, 0);
      if (k == 1) push(p, 1, UD, 1, 0, 1);
      else        push(p, 0, 3'd0, 0, 0, 1);
      run_txn((k == 1) ? 2'b01 : 2'b00, cyc);
      chk("dirty_miss_wb_cycles", wr_cnt, 1);
    end

    // Reset in the middle of ALLOCATE (ACE never answers).
    set_model(4'b0000, UC, UC, UC, UC);
    ace_delay = 1000;
    cpu_request = 2'b00;
    @(posedge clk); #1;
    cpu_request = 2'b11;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      if (read_req) seen = 1;
    end
    chk("alloc_reached", seen, 1);
    reset = 1'b1;
    #1;
    chk("midrst_ready_during", cache_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_read_req", read_req, 0);
    chk("midrst_ready", cache_ready, 1);
    chk("midrst_strobes", {state_we, write_from_interconnect, cache_complete}, 0);
    ace_delay = 1;
    @(posedge clk); #1;

    // Pointer must be back at 0 after reset.
    set_model(4'b0000, UD, UD, UD, UD);
    push(2'd0, 1, INV, 0, 0, 0);
    push(2'd0, 1, UC, 0, 1, 0);
    push(2'd0, 0, 3'd0, 0, 0, 1);
    run_txn(2'b00, cyc);

    // No-task code keeps the controller idle.
    cpu_request = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    cpu_request = 2'b11;
    chk("notask_ready", cache_ready, 1);
    chk("notask_reqs", {read_req, write_req, invalid_req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
